// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter that holds each grant until last beat, withdrawal or hold timeout
module rr_lock_arbiter #(
  parameter int ARB_NUM = 4,
  parameter int MAX_HOLD = 0,
  localparam int IDX_W = $clog2(ARB_NUM),
  localparam int HOLD_W = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic [ARB_NUM-1:0] iReq,
  input  logic [ARB_NUM-1:0] iLast,
  input  logic               iReady,
  output logic [ARB_NUM-1:0] oGnt,
  output logic [IDX_W-1:0]   oGntIdx,
  output logic               oBusy,
  output logic               oTimeout
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;
  logic [ARB_NUM-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, sel, base;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic tout_q, tout_d, busy, found, req_g, rel_a, rel_b, rel_c, rel, load;
  int pos;
  always_comb begin
    busy = state_q == BUSY;
    base = busy ? (idx_q == IDX_W'(ARB_NUM - 1) ? '0 : idx_q + 1'b1) : ptr_q;
    found = 1'b0;
    sel = '0;
    pos = 0;
    for (int k = ARB_NUM - 1; k >= 0; k--) begin
      pos = int'(base) + k;
      pos = pos >= ARB_NUM ? pos - ARB_NUM : pos;
      if (iReq[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        sel = pos[IDX_W-1:0];
      end
    end
    req_g = iReq[idx_q];
    rel_a = req_g && iReady && iLast[idx_q];
    rel_b = !req_g;
    rel_c = MAX_HOLD != 0 && cnt_q == HOLD_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0) && !rel_a && !rel_b;
    rel = busy && (rel_a || rel_b || rel_c);
    load = (!busy || rel) && found;
    state_d = load ? BUSY : rel ? IDLE : state_q;
    gnt_d = load ? (ARB_NUM'(1) << sel) : rel ? '0 : gnt_q;
    idx_d = load ? sel : idx_q;
    ptr_d = rel ? base : ptr_q;
    cnt_d = load ? '0 : &cnt_q ? cnt_q : cnt_q + 1'b1;
    tout_d = busy && rel_c;
  end
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      tout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      tout_q <= tout_d;
    end
  end
  assign oGnt = gnt_q;
  assign oGntIdx = idx_q;
  assign oBusy = state_q == BUSY;
  assign oTimeout = tout_q;
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: checks timeout and no-timeout builds against a cycle-level reference model
module tb_rr_lock_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0, last = '0;
  logic ready = 1'b0;
  logic [N-1:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic busy_a, busy_b, to_a, to_b;
  int n_tests = 0, n_fail = 0;
  int mh[2] = '{8, 0};
  int m_gnt[2], m_idx[2], m_ptr[2], m_held[2];
  logic m_to[2];
  logic [N-1:0] rot_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  rr_lock_arbiter #(.ARB_NUM(N), .MAX_HOLD(8)) dut_a (
    .iClk(clk), .iRst_n(rst_n), .iReq(req), .iLast(last), .iReady(ready),
    .oGnt(gnt_a), .oGntIdx(idx_a), .oBusy(busy_a), .oTimeout(to_a));
  rr_lock_arbiter #(.ARB_NUM(N), .MAX_HOLD(0)) dut_b (
    .iClk(clk), .iRst_n(rst_n), .iReq(req), .iLast(last), .iReady(ready),
    .oGnt(gnt_b), .oGntIdx(idx_b), .oBusy(busy_b), .oTimeout(to_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scan(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt(input int k);
    return m_gnt[k] < 0 ? '0 : N'(1) << m_gnt[k];
  endfunction

  task automatic step();
    int p, g;
    logic done, gone;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_gnt[k] = -1; m_idx[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_to[k] = 1'b0;
      end else if (m_gnt[k] < 0) begin
        p = scan(m_ptr[k], req);
        if (p >= 0) begin m_gnt[k] = p; m_idx[k] = p; m_held[k] = 1; end
        m_to[k] = 1'b0;
      end else begin
        g = m_gnt[k];
        done = req[g] && ready && last[g];
        gone = !req[g];
        m_to[k] = mh[k] != 0 && m_held[k] == mh[k] && !done && !gone;
        if (done || gone || m_to[k]) begin
          m_ptr[k] = (g + 1) % N;
          p = scan(m_ptr[k], req);
          m_gnt[k] = p;
          if (p >= 0) begin m_idx[k] = p; m_held[k] = 1; end
        end else m_held[k]++;
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd, input logic rs);
    req = r; last = l; ready = rd; rst_n = rs;
    @(posedge clk);
    step();
    @(negedge clk);
    check("gnt_a", 32'(gnt_a), 32'(exp_gnt(0)));
    check("idx_a", 32'(idx_a), 32'(m_idx[0]));
    check("busy_a", 32'(busy_a), 32'(m_gnt[0] >= 0));
    check("tout_a", 32'(to_a), 32'(m_to[0]));
    check("gnt_b", 32'(gnt_b), 32'(exp_gnt(1)));
    check("idx_b", 32'(idx_b), 32'(m_idx[1]));
    check("busy_b", 32'(busy_b), 32'(m_gnt[1] >= 0));
    check("tout_b", 32'(to_b), 32'(m_to[1]));
  endtask

  initial begin
    repeat (3) cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
    check("rst_gnt", 32'(gnt_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b1111, 1'b1, 1'b1);
      check("rot", 32'(gnt_a), 32'(rot_exp[i]));
    end
    check("rot_idx", 32'(idx_a), 32'h0);
    cyc('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0011, 4'b0000, 1'b1, 1'b1);
      check("lock", 32'(gnt_a), 32'h1);
    end
    cyc(4'b0011, 4'b0001, 1'b1, 1'b1);
    check("lock_rel", 32'(gnt_a), 32'h2);
    cyc('0, '0, 1'b0, 1'b0);
    cyc(4'b0100, 4'b0000, 1'b0, 1'b1);
    repeat (4) begin
      cyc(4'b0100, 4'b0100, 1'b0, 1'b1);
      check("bp_hold", 32'(gnt_a), 32'h4);
    end
    cyc(4'b1111, 4'b0100, 1'b1, 1'b1);
    check("bp_rel", 32'(gnt_a), 32'h8);
    cyc(4'b0100, 4'b0000, 1'b1, 1'b1);
    check("wrap", 32'(gnt_a), 32'h4);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b1);
    check("idle_gnt", 32'(gnt_a), 32'h0);
    check("idle_busy", 32'(busy_a), 32'h0);
    cyc('0, '0, 1'b0, 1'b0);
    repeat (8) begin
      cyc(4'b0101, 4'b0000, 1'b1, 1'b1);
      check("to_hold", 32'(gnt_a), 32'h1);
    end
    cyc(4'b0101, 4'b0000, 1'b1, 1'b1);
    check("to_gnt", 32'(gnt_a), 32'h4);
    check("to_pulse", 32'(to_a), 32'h1);
    check("nto_gnt", 32'(gnt_b), 32'h1);
    cyc(4'b0101, 4'b0000, 1'b1, 1'b1);
    check("to_once", 32'(to_a), 32'h0);
    repeat (2000) begin
      cyc(N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 63) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
